// File: rtl/tpu_command_assembler_if.sv
// ============================================================================
// Module   : tpu_command_assembler_if
// Brief    : Byte-in / command-out bus between a byte source, the command
//            assembler and the TPU execute/busy handshake.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface tpu_command_assembler_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tpu_busy;
    logic        execute;
    logic [47:0] command;

    modport master (
        output rx_valid,
        output rx_data,
        output tpu_busy,
        input  execute,
        input  command
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  tpu_busy,
        output execute,
        output command
    );
endinterface

`default_nettype wire

// File: rtl/tpu_command_assembler.sv
// ============================================================================
// Module   : tpu_command_assembler
// Brief    : FWFT byte FIFO feeding an opcode-driven command assembler that
//            issues complete TPU commands via execute/busy. Optional partial-
//            command timeout is enabled by defining COMMAND_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

`ifndef TPU_CLEARSCREEN
`define TPU_CLEARSCREEN 8'h01
`endif
`ifndef TPU_PRINT
`define TPU_PRINT 8'h02
`endif
`ifndef TPU_LOCATE
`define TPU_LOCATE 8'h03
`endif
`ifndef TPU_SETATTR
`define TPU_SETATTR 8'h04
`endif
`ifndef TPU_SETMASK
`define TPU_SETMASK 8'h05
`endif
`ifndef TPU_FILLAREA
`define TPU_FILLAREA 8'h06
`endif

module tpu_command_assembler #(
    parameter int FIFO_AW = 4
`ifdef COMMAND_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 100000
`endif
) (
    input  wire                   clk,
    input  wire                   reset,
    tpu_command_assembler_if.slave bus,
    output logic                  overflow,
    output logic                  bad_opcode,
    output logic                  timeout_drop,
    output logic [FIFO_AW:0]      fifo_level
);

    localparam int             DEPTH      = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_WAIT    = 3'd2,
        S_ISSUE   = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    // Total command length including the opcode; 0 marks an unknown opcode.
    function automatic logic [2:0] cmd_length(input logic [7:0] op);
        case (op)
            `TPU_CLEARSCREEN: cmd_length = 3'd1;
            `TPU_PRINT:       cmd_length = 3'd2;
            `TPU_LOCATE:      cmd_length = 3'd3;
            `TPU_SETATTR:     cmd_length = 3'd3;
            `TPU_SETMASK:     cmd_length = 3'd4;
            `TPU_FILLAREA:    cmd_length = 3'd4;
            default:          cmd_length = 3'd0;
        endcase
    endfunction

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic               r_overflow;

    state_t             r_state;
    logic [47:0]        r_command;
    logic               r_execute;
    logic               r_bad_opcode;
    logic [2:0]         r_remaining;
    logic [2:0]         r_slot;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [7:0]         w_head;
    logic [2:0]         w_len;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == FULL_LEVEL);
    assign w_push  = bus.rx_valid && !w_full;
    assign w_pop   = !w_empty && ((r_state == S_IDLE) || (r_state == S_COLLECT));
    assign w_head  = r_mem[r_rd_ptr];
    assign w_len   = cmd_length(w_head);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            // A full FIFO rejects the byte even if a pop frees a slot this cycle.
            if (bus.rx_valid && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef COMMAND_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_W-1:0] r_timer;
    logic               r_timeout_drop;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_command    <= '0;
            r_execute    <= 1'b0;
            r_bad_opcode <= 1'b0;
            r_remaining  <= '0;
            r_slot       <= '0;
`ifdef COMMAND_TIMEOUT_EN
            r_timer        <= '0;
            r_timeout_drop <= 1'b0;
`endif
        end else begin
            r_execute    <= 1'b0;
            r_bad_opcode <= 1'b0;
`ifdef COMMAND_TIMEOUT_EN
            r_timeout_drop <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
`ifdef COMMAND_TIMEOUT_EN
                    r_timer <= '0;
`endif
                    if (!w_empty) begin
                        if (w_len == 3'd0) begin
                            r_bad_opcode <= 1'b1;
                        end else begin
                            r_command   <= {40'h0, w_head};
                            r_remaining <= w_len - 3'd1;
                            r_slot      <= 3'd1;
                            r_state     <= (w_len == 3'd1) ? S_WAIT : S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (!w_empty) begin
                        r_command[{r_slot, 3'b000} +: 8] <= w_head;
                        r_slot      <= r_slot + 3'd1;
                        r_remaining <= r_remaining - 3'd1;
`ifdef COMMAND_TIMEOUT_EN
                        r_timer     <= '0;
`endif
                        if (r_remaining == 3'd1) begin
                            r_state <= S_WAIT;
                        end
                    end
`ifdef COMMAND_TIMEOUT_EN
                    else if (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                        r_timer        <= '0;
                        r_timeout_drop <= 1'b1;
                        r_state        <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
`endif
                end
                S_WAIT: begin
                    if (!bus.tpu_busy) begin
                        r_execute <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef COMMAND_TIMEOUT_EN
    assign timeout_drop = r_timeout_drop;
`else
    assign timeout_drop = 1'b0;
`endif

    assign bus.execute = r_execute;
    assign bus.command = r_command;
    assign overflow    = r_overflow;
    assign bad_opcode  = r_bad_opcode;
    assign fifo_level  = r_level;

endmodule

`default_nettype wire

// File: tb/tb_tpu_command_assembler.sv
// ============================================================================
// Module   : tb_tpu_command_assembler
// Brief    : Self-checking bench: command table plus hand-written corner cases,
//            with a queue scoreboard checked on every execute strobe.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

`ifndef TPU_CLEARSCREEN
`define TPU_CLEARSCREEN 8'h01
`endif
`ifndef TPU_PRINT
`define TPU_PRINT 8'h02
`endif
`ifndef TPU_LOCATE
`define TPU_LOCATE 8'h03
`endif
`ifndef TPU_SETATTR
`define TPU_SETATTR 8'h04
`endif
`ifndef TPU_SETMASK
`define TPU_SETMASK 8'h05
`endif
`ifndef TPU_FILLAREA
`define TPU_FILLAREA 8'h06
`endif

module tb_tpu_command_assembler;

    localparam int FIFO_AW = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               overflow;
    logic               bad_opcode;
    logic               timeout_drop;
    logic [FIFO_AW:0]   fifo_level;

    tpu_command_assembler_if bus();

`ifdef COMMAND_TIMEOUT_EN
    tpu_command_assembler #(.FIFO_AW(FIFO_AW), .TIMEOUT_CYCLES(50)) dut (
`else
    tpu_command_assembler #(.FIFO_AW(FIFO_AW)) dut (
`endif
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .overflow     (overflow),
        .bad_opcode   (bad_opcode),
        .timeout_drop (timeout_drop),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_push_cyc = 0;
    int          exec_cyc = 0;
    int          n_exec   = 0;
    int          n_bad    = 0;
    int          n_tmo    = 0;
    logic        busy_q   = 1'b0;
    logic        exec_prev = 1'b0;
    logic [47:0] exp_q[$];

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        busy_q <= bus.tpu_busy;
    end

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: each execute must match the oldest expected command.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.execute) begin
                    n_exec++;
                    exec_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_execute: got command %h expected no execute", bus.command);
                    end else begin
                        check("command", bus.command, exp_q.pop_front());
                    end
                    check("busy_before_execute", 48'(busy_q), 48'h0);
                    check("no_back_to_back", 48'(exec_prev), 48'h0);
                end
                if (bad_opcode)   n_bad++;
                if (timeout_drop) n_tmo++;
            end
            exec_prev = bus.execute;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        bus.rx_valid  = 1'b1;
        bus.rx_data   = b;
        last_push_cyc = cyc;
        @(posedge clk);
        #1;
        bus.rx_valid  = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            idle(1);
            t++;
        end
        check({name, "_drain_left"}, 48'(exp_q.size()), 48'h0);
        exp_q.delete();
        idle(5);
    endtask

    typedef struct {
        logic [7:0]  b [4];
        int          len;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int n0;
        int m;
        logic [7:0] burst [17];

        vecs[0] = '{'{`TPU_CLEARSCREEN, 8'h00, 8'h00, 8'h00}, 1, 48'h0000_0000_0001};
        vecs[1] = '{'{`TPU_PRINT,       8'h41, 8'h00, 8'h00}, 2, 48'h0000_0000_4102};
        vecs[2] = '{'{`TPU_LOCATE,      8'h05, 8'h0A, 8'h00}, 3, 48'h0000_000A_0503};
        vecs[3] = '{'{`TPU_SETATTR,     8'h1F, 8'h70, 8'h00}, 3, 48'h0000_0070_1F04};
        vecs[4] = '{'{`TPU_SETMASK,     8'hAA, 8'h55, 8'h0F}, 4, 48'h0000_0F55_AA05};
        vecs[5] = '{'{`TPU_FILLAREA,    8'h01, 8'h02, 8'h03}, 4, 48'h0000_0302_0106};
        vecs[6] = '{'{`TPU_LOCATE,      8'hFF, 8'h00, 8'h00}, 3, 48'h0000_0000_FF03};

        burst = '{8'h02, 8'h33, 8'h03, 8'h11, 8'h22, 8'h04, 8'h44, 8'h55,
                  8'h05, 8'h66, 8'h77, 8'h88, 8'h01, 8'h03, 8'h99, 8'hAA, 8'h01};

        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tpu_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_execute",      48'(bus.execute),  48'h0);
        check("rst_command",      bus.command,       48'h0);
        check("rst_overflow",     48'(overflow),     48'h0);
        check("rst_bad_opcode",   48'(bad_opcode),   48'h0);
        check("rst_timeout_drop", 48'(timeout_drop), 48'h0);
        check("rst_fifo_level",   48'(fifo_level),   48'h0);

        // Locate command: latency from last byte to execute.
        n0 = n_exec;
        exp_q.push_back(48'h0000_000A_0503);
        push(`TPU_LOCATE);
        push(8'h05);
        push(8'h0A);
        m = last_push_cyc;
        drain("t1");
        check("t1_latency", 48'(exec_cyc - m), 48'd3);
        check("t1_exec_count", 48'(n_exec - n0), 48'd1);

        // Busy TPU holds the command until busy drops.
        n0 = n_exec;
        bus.tpu_busy = 1'b1;
        exp_q.push_back(48'h0000_0000_4102);
        push(`TPU_PRINT);
        push(8'h41);
        idle(10);
        check("t2_no_exec_while_busy", 48'(n_exec - n0), 48'd0);
        m = cyc;
        bus.tpu_busy = 1'b0;
        drain("t2");
        check("t2_latency_after_busy", 48'(exec_cyc - m), 48'd1);

        // Table of all opcodes streamed back-to-back.
        n0 = n_exec;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(vecs[i].exp);
            for (int k = 0; k < vecs[i].len; k++) begin
                push(vecs[i].b[k]);
            end
        end
        drain("table");
        check("table_exec_count", 48'(n_exec - n0), 48'd7);
        check("table_no_overflow", 48'(overflow), 48'h0);

        // Unknown opcode discarded, next command unaffected.
        n0 = n_bad;
        exp_q.push_back(48'h0000_0000_0001);
        push(8'hFF);
        push(`TPU_CLEARSCREEN);
        drain("t4");
        check("t4_bad_opcode_pulses", 48'(n_bad - n0), 48'd1);

        // Partial command followed by silence.
        n0 = n_exec;
        push(`TPU_FILLAREA);
        push(8'h27);
        push(8'h18);
`ifdef COMMAND_TIMEOUT_EN
        m = n_tmo;
        idle(100);
        check("t5_timeout_pulses", 48'(n_tmo - m), 48'd1);
        check("t5_no_exec", 48'(n_exec - n0), 48'd0);
`else
        idle(200);
        check("t5_no_exec", 48'(n_exec - n0), 48'd0);
        check("t5_no_timeout", 48'(n_tmo), 48'd0);
        exp_q.push_back(48'h0000_2A18_2706);
        push(8'h2A);
        drain("t5");
        check("t5_exec_after_last_byte", 48'(n_exec - n0), 48'd1);
`endif

        // Overflow: assembler parked in WAIT, 17 bytes into a 16-deep FIFO.
        n0 = n_exec;
        bus.tpu_busy = 1'b1;
        exp_q.push_back(48'h0000_0000_0001);
        push(`TPU_CLEARSCREEN);
        idle(3);
        exp_q.push_back(48'h0000_0000_3302);
        exp_q.push_back(48'h0000_0022_1103);
        exp_q.push_back(48'h0000_0055_4404);
        exp_q.push_back(48'h0000_8877_6605);
        exp_q.push_back(48'h0000_0000_0001);
        exp_q.push_back(48'h0000_00AA_9903);
        for (int i = 0; i < 17; i++) begin
            push(burst[i]);
        end
        check("t3_fifo_level_full", 48'(fifo_level), 48'd16);
        check("t3_overflow_set", 48'(overflow), 48'h1);
        bus.tpu_busy = 1'b0;
        drain("t3");
        check("t3_overflow_sticky", 48'(overflow), 48'h1);
        check("t3_exec_count", 48'(n_exec - n0), 48'd7);
        check("t3_fifo_empty", 48'(fifo_level), 48'd0);

        // Reset with buffered bytes drops everything.
        n0 = n_exec;
        bus.tpu_busy = 1'b1;
        push(`TPU_CLEARSCREEN);
        idle(3);
        push(`TPU_FILLAREA);
        push(8'h27);
        push(8'h18);
        check("t6_fifo_level_before", 48'(fifo_level), 48'd3);
        reset = 1'b1;
        idle(1);
        check("t6_execute",      48'(bus.execute),  48'h0);
        check("t6_command",      bus.command,       48'h0);
        check("t6_overflow",     48'(overflow),     48'h0);
        check("t6_bad_opcode",   48'(bad_opcode),   48'h0);
        check("t6_timeout_drop", 48'(timeout_drop), 48'h0);
        check("t6_fifo_level",   48'(fifo_level),   48'h0);
        reset = 1'b0;
        bus.tpu_busy = 1'b0;
        idle(30);
        check("t6_no_exec_after_reset", 48'(n_exec - n0), 48'd0);

        check("final_scoreboard_empty", 48'(exp_q.size()), 48'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
